// File: rtl/seg7_scan_if.sv
// Display readback bus: scanned segment/digit-enable lines in, assembled BCD frame out
// with a valid/ready handshake and an overrun flag.
interface seg7_scan_if #(
    parameter int NUM_DIGITS = 4
);
    logic [6:0]              segIn;
    logic [NUM_DIGITS-1:0]   digitSel;
    logic [4*NUM_DIGITS-1:0] frameBCD;
    logic [NUM_DIGITS-1:0]   frameErr;
    logic                    frameValid;
    logic                    frameReady;
    logic                    overrun;

    // Side that drives the display lines and consumes frames
    modport master (
        output segIn, digitSel, frameReady,
        input  frameBCD, frameErr, frameValid, overrun
    );

    // Decoder side
    modport slave (
        input  segIn, digitSel, frameReady,
        output frameBCD, frameErr, frameValid, overrun
    );
endinterface

// File: rtl/seg7_scan_decoder.sv
// Recovers BCD digits from a multiplexed common-cathode seven-segment bus.
// Each {seg,sel} dwell is sampled once after it has been stable long enough,
// decoded back to BCD, and staged until every digit has been seen; the finished
// frame is then offered on a valid/ready output.
module seg7_scan_decoder #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 8
) (
    input logic        clk,
    input logic        rst_n,
    seg7_scan_if.slave bus
);
    localparam int CNT_W = $clog2(STABLE_CYCLES + 2);
    localparam logic [CNT_W-1:0] CNT_SAMPLE = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(STABLE_CYCLES + 1);

    logic [6:0]              seg_p0;
    logic [NUM_DIGITS-1:0]   sel_p0;
    logic [CNT_W-1:0]        cnt_p0;
    logic [NUM_DIGITS-1:0]   mask;
    logic [4*NUM_DIGITS-1:0] stage_bcd;
    logic [NUM_DIGITS-1:0]   stage_err;

    logic                    changed;
    logic                    sample;
    logic                    complete;
    logic [4:0]              dec;
    logic [4*NUM_DIGITS-1:0] next_bcd;
    logic [NUM_DIGITS-1:0]   next_err;

    // {err, nibble}; anything that is not a clean 0-9 glyph (blank included) is an error
    function automatic logic [4:0] decode_seg(input logic [6:0] s);
        case (s)
            7'h7E:   decode_seg = {1'b0, 4'd0};
            7'h30:   decode_seg = {1'b0, 4'd1};
            7'h6D:   decode_seg = {1'b0, 4'd2};
            7'h79:   decode_seg = {1'b0, 4'd3};
            7'h33:   decode_seg = {1'b0, 4'd4};
            7'h5B:   decode_seg = {1'b0, 4'd5};
            7'h5F:   decode_seg = {1'b0, 4'd6};
            7'h70:   decode_seg = {1'b0, 4'd7};
            7'h7F:   decode_seg = {1'b0, 4'd8};
            7'h7B:   decode_seg = {1'b0, 4'd9};
            default: decode_seg = {1'b1, 4'hF};
        endcase
    endfunction

    // Dwell detection, sample qualification and the frame as it would look with this sample merged in
    always_comb begin
        changed  = (bus.segIn != seg_p0) || (bus.digitSel != sel_p0);
        sample   = (cnt_p0 == CNT_SAMPLE) && $onehot(sel_p0);
        complete = &(mask | sel_p0);
        dec      = decode_seg(seg_p0);
        next_bcd = stage_bcd;
        next_err = stage_err;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (sel_p0[i]) begin
                next_bcd[4*i +: 4] = dec[3:0];
                next_err[i]        = dec[4];
            end
        end
    end

    // ---- stage p0: input register and stability counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_p0 <= '0;
            sel_p0 <= '0;
            cnt_p0 <= '0;
        end else begin
            seg_p0 <= bus.segIn;
            sel_p0 <= bus.digitSel;
            if (changed)
                cnt_p0 <= '0;
            else if (cnt_p0 != CNT_MAX)
                cnt_p0 <= cnt_p0 + CNT_W'(1);
        end
    end

    // ---- stage p1: digit staging, frame completion and output handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask           <= '0;
            stage_bcd      <= '0;
            stage_err      <= '0;
            bus.frameBCD   <= '0;
            bus.frameErr   <= '0;
            bus.frameValid <= 1'b0;
            bus.overrun    <= 1'b0;
        end else begin
            bus.overrun <= 1'b0;
            if (bus.frameValid && bus.frameReady)
                bus.frameValid <= 1'b0;
            if (sample) begin
                stage_bcd <= next_bcd;
                stage_err <= next_err;
                if (complete) begin
                    mask <= '0;
                    if (!bus.frameValid || bus.frameReady) begin
                        bus.frameBCD   <= next_bcd;
                        bus.frameErr   <= next_err;
                        bus.frameValid <= 1'b1;
                    end else begin
                        bus.overrun <= 1'b1;
                    end
                end else begin
                    mask <= mask | sel_p0;
                end
            end
        end
    end
endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Bench for seg7_scan_decoder: dwell-level reference model of the display readback.
module tb_seg7_scan_decoder;
    localparam int ST = 8;

    logic clk = 1'b0;
    logic rst_n;
    seg7_scan_if #(.NUM_DIGITS(4)) bus ();

    seg7_scan_decoder #(.NUM_DIGITS(4), .STABLE_CYCLES(ST)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    string cur = "init";

    logic [6:0] glyph [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
                               7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};

    // reference model state
    bit         m_valid;
    logic [15:0] m_bcd;
    logic [3:0]  m_err;
    bit         m_ovr;
    logic [3:0] m_digit [4];
    bit         m_derr [4];
    bit         m_have [4];

    // observation bookkeeping
    bit         prev_v;
    int         rises, vcyc, ovr_seen, rise_k;
    logic [15:0] rise_bcd;
    logic [3:0]  rise_err;
    logic [6:0] last_s;
    logic [3:0] last_sel;

    function automatic logic [4:0] ref_decode(input logic [6:0] s);
        for (int d = 0; d < 10; d++)
            if (glyph[d] == s) return {1'b0, 4'(d)};
        return {1'b1, 4'hF};
    endfunction

    task automatic model_reset();
        m_valid = 0; m_bcd = '0; m_err = '0; m_ovr = 0;
        for (int i = 0; i < 4; i++) begin
            m_digit[i] = '0; m_derr[i] = 0; m_have[i] = 0;
        end
        prev_v = 0;
    endtask

    task automatic clear_obs();
        rises = 0; vcyc = 0; ovr_seen = 0; rise_k = -1;
        rise_bcd = '0; rise_err = '0;
    endtask

    task automatic model_edge(input bit smp, input logic [6:0] s, input logic [3:0] sel);
        bit pv, all;
        logic [4:0] d;
        int idx;
        pv = m_valid;
        m_ovr = 0;
        if (pv && bus.frameReady) m_valid = 0;
        if (smp) begin
            d = ref_decode(s);
            idx = 0;
            for (int i = 0; i < 4; i++) if (sel[i]) idx = i;
            m_digit[idx] = d[3:0];
            m_derr[idx]  = d[4];
            m_have[idx]  = 1;
            all = 1;
            for (int i = 0; i < 4; i++) all = all & m_have[i];
            if (all) begin
                for (int i = 0; i < 4; i++) m_have[i] = 0;
                if (!pv || bus.frameReady) begin
                    m_valid = 1;
                    m_bcd = {m_digit[3], m_digit[2], m_digit[1], m_digit[0]};
                    m_err = {m_derr[3], m_derr[2], m_derr[1], m_derr[0]};
                end else begin
                    m_ovr = 1;
                end
            end
        end
    endtask

    // Present one {seg,sel} dwell for n cycles; n must avoid ST+1 (sample would land in the next dwell)
    task automatic show(input logic [6:0] s, input logic [3:0] sel, input int n);
        bit cap;
        cap = ($countones(sel) == 1) && (n >= ST + 2);
        bus.segIn = s;
        bus.digitSel = sel;
        last_s = s;
        last_sel = sel;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            model_edge(cap && (k == ST + 1), s, sel);
            #1;
            checks++;
            if (bus.frameValid !== m_valid || bus.frameBCD !== m_bcd ||
                bus.frameErr !== m_err || bus.overrun !== m_ovr) begin
                errors++;
                $display("FAIL %s k=%0d got valid=%b bcd=%h err=%b ovr=%b, want valid=%b bcd=%h err=%b ovr=%b",
                         cur, k, bus.frameValid, bus.frameBCD, bus.frameErr, bus.overrun,
                         m_valid, m_bcd, m_err, m_ovr);
            end
            if (bus.frameValid === 1'b1) vcyc++;
            if (bus.overrun === 1'b1) ovr_seen++;
            if (bus.frameValid === 1'b1 && !prev_v) begin
                rises++; rise_k = k; rise_bcd = bus.frameBCD; rise_err = bus.frameErr;
            end
            prev_v = (bus.frameValid === 1'b1);
        end
    endtask

    task automatic idle(input int n);
        show(7'h00, 4'b0000, n);
    endtask

    task automatic scan4(input int d0, input int d1, input int d2, input int d3);
        show(glyph[d0], 4'b0001, 12);
        show(glyph[d1], 4'b0010, 12);
        show(glyph[d2], 4'b0100, 12);
        show(glyph[d3], 4'b1000, 12);
    endtask

    task automatic test_reset();
        cur = "reset";
        rst_n = 1'b0;
        bus.segIn = '0; bus.digitSel = '0; bus.frameReady = 1'b0;
        model_reset();
        clear_obs();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.frameValid !== 1'b0 || bus.frameBCD !== 16'h0 || bus.frameErr !== 4'h0 || bus.overrun !== 1'b0) begin
            errors++;
            $display("FAIL reset_initial got valid=%b bcd=%h err=%b ovr=%b, want all 0",
                     bus.frameValid, bus.frameBCD, bus.frameErr, bus.overrun);
        end
        rst_n = 1'b1;
        // hold a frame, then capture two digits and reset in the middle of the third dwell
        scan4(1, 2, 3, 4);
        show(glyph[5], 4'b0001, 12);
        show(glyph[6], 4'b0010, 12);
        bus.segIn = glyph[7]; bus.digitSel = 4'b0100;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        bus.segIn = '0; bus.digitSel = '0;
        #1;
        checks++;
        if (bus.frameValid !== 1'b0 || bus.frameBCD !== 16'h0 || bus.frameErr !== 4'h0 || bus.overrun !== 1'b0) begin
            errors++;
            $display("FAIL reset_midframe got valid=%b bcd=%h err=%b ovr=%b, want all 0",
                     bus.frameValid, bus.frameBCD, bus.frameErr, bus.overrun);
        end
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cur = "reset_refill";
        clear_obs();
        show(glyph[8], 4'b0100, 12);
        show(glyph[9], 4'b1000, 12);
        show(glyph[1], 4'b0010, 12);
        checks++;
        if (rises !== 0) begin
            errors++;
            $display("FAIL reset_partial frames=%0d, want 0", rises);
        end
        show(glyph[0], 4'b0001, 12);
        checks++;
        if (rises !== 1 || rise_bcd !== 16'h9810) begin
            errors++;
            $display("FAIL reset_refill frames=%0d bcd=%h, want 1 and 9810", rises, rise_bcd);
        end
    endtask

    task automatic test_scan();
        cur = "scan";
        bus.frameReady = 1'b1;
        idle(3);
        clear_obs();
        scan4(3, 1, 4, 9);
        idle(4);
        checks++;
        if (rises !== 1 || rise_bcd !== 16'h9413 || rise_err !== 4'b0000 || vcyc !== 1) begin
            errors++;
            $display("FAIL scan frames=%0d bcd=%h err=%b valid_cycles=%0d, want 1 9413 0000 1",
                     rises, rise_bcd, rise_err, vcyc);
        end
    endtask

    task automatic test_glitch();
        cur = "glitch";
        bus.frameReady = 1'b1;
        clear_obs();
        show(glyph[2], 4'b0001, 12);
        show(glyph[2], 4'b0010, 12);
        show(glyph[2], 4'b0100, 12);
        show(glyph[8], 4'b1000, 5);
        checks++;
        if (rises !== 0) begin
            errors++;
            $display("FAIL glitch_capture frames=%0d, want 0", rises);
        end
        show(glyph[6], 4'b1000, 12);
        checks++;
        if (rises !== 1 || rise_k !== ST + 1 || rise_bcd !== 16'h6222) begin
            errors++;
            $display("FAIL glitch_latency frames=%0d edge=%0d bcd=%h, want 1 %0d 6222",
                     rises, rise_k, rise_bcd, ST + 1);
        end
    endtask

    task automatic test_invalid();
        cur = "invalid";
        bus.frameReady = 1'b1;
        clear_obs();
        show(glyph[1], 4'b0001, 12);
        show(glyph[2], 4'b0010, 12);
        show(7'b1000001, 4'b0100, 12);
        show(glyph[5], 4'b1000, 12);
        checks++;
        if (rises !== 1 || rise_bcd !== 16'h5F21 || rise_err !== 4'b0100) begin
            errors++;
            $display("FAIL invalid frames=%0d bcd=%h err=%b, want 1 5F21 0100", rises, rise_bcd, rise_err);
        end
    endtask

    task automatic test_overrun();
        cur = "overrun";
        bus.frameReady = 1'b0;
        idle(2);
        clear_obs();
        scan4(1, 2, 3, 4);
        scan4(5, 6, 7, 8);
        checks++;
        if (rises !== 1 || ovr_seen !== 1 || bus.frameBCD !== 16'h4321 || bus.frameValid !== 1'b1) begin
            errors++;
            $display("FAIL overrun frames=%0d pulses=%0d bcd=%h valid=%b, want 1 1 4321 1",
                     rises, ovr_seen, bus.frameBCD, bus.frameValid);
        end
        bus.frameReady = 1'b1;
        idle(3);
        checks++;
        if (bus.frameValid !== 1'b0) begin
            errors++;
            $display("FAIL overrun_accept valid=%b, want 0", bus.frameValid);
        end
    endtask

    task automatic test_blank_resample();
        cur = "blank";
        bus.frameReady = 1'b1;
        clear_obs();
        show(glyph[3], 4'b0000, 20);
        show(glyph[3], 4'b0011, 20);
        show(glyph[1], 4'b0010, 12);
        show(glyph[2], 4'b0100, 12);
        show(glyph[3], 4'b1000, 12);
        checks++;
        if (rises !== 0) begin
            errors++;
            $display("FAIL blank_capture frames=%0d, want 0", rises);
        end
        show(glyph[5], 4'b0001, 12);
        checks++;
        if (rises !== 1 || rise_bcd !== 16'h3215) begin
            errors++;
            $display("FAIL blank_frame frames=%0d bcd=%h, want 1 3215", rises, rise_bcd);
        end
        cur = "resample";
        idle(3);
        clear_obs();
        show(glyph[5], 4'b0001, 12);
        show(glyph[7], 4'b0001, 12);
        show(glyph[1], 4'b0010, 12);
        show(glyph[2], 4'b0100, 12);
        show(glyph[3], 4'b1000, 12);
        checks++;
        if (rises !== 1 || rise_bcd !== 16'h3217) begin
            errors++;
            $display("FAIL resample frames=%0d bcd=%h, want 1 3217", rises, rise_bcd);
        end
    endtask

    task automatic test_random();
        logic [6:0] s;
        logic [3:0] sel;
        int n;
        cur = "random";
        clear_obs();
        for (int t = 0; t < 60; t++) begin
            do begin
                if ($urandom_range(0, 9) < 7) s = glyph[$urandom_range(0, 9)];
                else s = 7'($urandom);
                if ($urandom_range(0, 9) < 8) sel = 4'b0001 << $urandom_range(0, 3);
                else sel = 4'($urandom);
            end while (s == last_s && sel == last_sel);
            if ($urandom_range(0, 3) == 0) n = $urandom_range(2, ST);
            else n = $urandom_range(ST + 2, ST + 6);
            bus.frameReady = ($urandom_range(0, 2) != 0);
            show(s, sel, n);
        end
        bus.frameReady = 1'b1;
        idle(3);
    endtask

    initial begin
        last_s = '0;
        last_sel = '0;
        test_reset();
        test_scan();
        test_glitch();
        test_invalid();
        test_overrun();
        test_blank_resample();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
